// File: rtl/msdf_otf_converter.sv
// On-the-fly (Q/QM) converter: radix-2 signed-digit MSDF stream to an (N+1)-bit
// two's-complement word, presented on a valid/ready output register.
module msdf_otf_converter #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   zj,
    input  logic         zj_valid,
    input  logic         flush,
    output logic [N:0]   res_data,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         busy,
    output logic         err,
    output logic         ovf
);

    localparam logic [1:0] R2_POS_ONE = 2'b01;
    localparam logic [1:0] R2_ZERO    = 2'b00;
    localparam logic [1:0] R2_NEG_ONE = 2'b11;

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [N:0]  QInit  = '0;
    localparam logic [N:0]  QmInit = {(N + 1){1'b1}};

    logic [N:0]    q_q, q_d;
    logic [N:0]    qm_q, qm_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N:0]    res_data_q, res_data_d;
    logic          res_valid_q, res_valid_d;
    logic          err_q, err_d;
    logic          ovf_q, ovf_d;

    logic [N:0] q_shift;
    logic [N:0] qm_shift;
    logic       illegal;
    logic       last_digit;
    logic       complete;

    // Append the incoming digit to Q/QM; QM == Q-1 is preserved by construction.
    always_comb begin
        q_shift  = q_q;
        qm_shift = qm_q;
        illegal  = 1'b0;
        case (zj)
            R2_POS_ONE: begin
                q_shift  = {q_q[N-1:0], 1'b1};
                qm_shift = {q_q[N-1:0], 1'b0};
            end
            R2_NEG_ONE: begin
                q_shift  = {qm_q[N-1:0], 1'b1};
                qm_shift = {qm_q[N-1:0], 1'b0};
            end
            default: begin
                q_shift  = {q_q[N-1:0], 1'b0};
                qm_shift = {qm_q[N-1:0], 1'b1};
                illegal  = (zj != R2_ZERO);
            end
        endcase
    end

    always_comb begin
        last_digit  = (cnt_q == CW'(N - 1));
        complete    = zj_valid & ~flush & last_digit;

        q_d         = q_q;
        qm_d        = qm_q;
        cnt_d       = cnt_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        err_d       = err_q;
        ovf_d       = ovf_q;

        if (flush) begin
            q_d   = QInit;
            qm_d  = QmInit;
            cnt_d = '0;
            err_d = 1'b0;
            ovf_d = 1'b0;
        end else if (zj_valid) begin
            if (illegal) begin
                err_d = 1'b1;
            end
            if (last_digit) begin
                q_d   = QInit;
                qm_d  = QmInit;
                cnt_d = '0;
            end else begin
                q_d   = q_shift;
                qm_d  = qm_shift;
                cnt_d = cnt_q + CW'(1);
            end
        end

        // A completing frame may refill the register on the same edge it is drained.
        if (complete) begin
            if (!res_valid_q || res_ready) begin
                res_data_d  = q_shift;
                res_valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q         <= QInit;
            qm_q        <= QmInit;
            cnt_q       <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            q_q         <= q_d;
            qm_q        <= qm_d;
            cnt_q       <= cnt_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
        end
    end

    assign res_data  = res_data_q;
    assign res_valid = res_valid_q;
    assign busy      = (cnt_q != '0);
    assign err       = err_q;
    assign ovf       = ovf_q;

endmodule
